// File: rtl/etapa_mem_wb.sv
// Memory-access / write-back stage.
// Sits behind the EX/MEM register: non-memory instructions pass straight
// through to the MEM/WB bundle in one cycle; loads and stores run a req/ack
// transaction on the data memory while the upstream pipeline is held.
// Misaligned accesses and transactions that never complete set a sticky
// error flag and retire as bubbles.
module etapa_mem_wb #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic [REG_AW-1:0] dir_wb_in,
    input  logic              mem_wr_in,
    input  logic              sel_wb_in,
    input  logic              reg_wr_in,
    input  logic              sel_ld_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    output logic              dm_req,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] result_out,
    output logic [REG_AW-1:0] dir_wb_out,
    output logic              reg_wr_out,
    output logic              mem_err,
    input  logic              err_clr
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Counter is 8 bits wide: MAX_WAIT is limited to 1..255.
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [0:0]        state_r;
    logic [7:0]        cnt_r;
    logic [REG_AW-1:0] dir_lat_r;
    logic              reg_wr_lat_r;
    logic              sel_wb_lat_r;

    logic access_s;
    logic misaligned_s;
    logic start_s;
    logic mis_err_s;
    logic ack_s;
    logic timeout_s;
    logic cnt_max_s;

    // Decode the incoming instruction and the transaction-ending events.
    always_comb begin
        access_s     = mem_wr_in | sel_ld_in;
        misaligned_s = (alu_in[1:0] != 2'b00);
        cnt_max_s    = (cnt_r == MAX_WAIT_C);
        start_s      = 1'b0;
        mis_err_s    = 1'b0;
        ack_s        = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s   = access_s & ~misaligned_s;
                mis_err_s = access_s & misaligned_s;
            end
            ST_WAIT: begin
                ack_s     = dm_ack;
                timeout_s = ~dm_ack & cnt_max_s;
            end
            default: begin
                start_s   = 1'b0;
                mis_err_s = 1'b0;
            end
        endcase
    end

    // Upstream hold: raised while a transaction is being launched or is
    // outstanding, released combinationally in the ack/abort cycle so the
    // EX/MEM register advances on that same edge.
    always_comb begin
        stall_out = 1'b0;
        if (!rst_n) begin
            stall_out = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: stall_out = start_s;
                ST_WAIT: stall_out = ~(dm_ack | cnt_max_s);
                default: stall_out = 1'b0;
            endcase
        end
    end

    // Transaction sequencer: state, wait counter, memory request signals and
    // the write-back fields captured at launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            dir_lat_r    <= '0;
            reg_wr_lat_r <= 1'b0;
            sel_wb_lat_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        dm_addr      <= alu_in;
                        dm_wdata     <= B_in;
                        dm_we        <= mem_wr_in;
                        dm_req       <= 1'b1;
                        cnt_r        <= 8'd0;
                        dir_lat_r    <= dir_wb_in;
                        reg_wr_lat_r <= reg_wr_in;
                        sel_wb_lat_r <= sel_wb_in;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ack_s || timeout_s) begin
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    dm_req  <= 1'b0;
                    dm_we   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // MEM/WB bundle: pass-through, load/store completion, or bubble
    // (only reg_wr_out is cleared; the other fields hold).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_out <= '0;
            dir_wb_out <= '0;
            reg_wr_out <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!access_s) begin
                        result_out <= alu_in;
                        dir_wb_out <= dir_wb_in;
                        reg_wr_out <= reg_wr_in;
                    end else begin
                        reg_wr_out <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (ack_s) begin
                        result_out <= (sel_wb_lat_r && !dm_we) ? dm_rdata : dm_addr;
                        dir_wb_out <= dir_lat_r;
                        reg_wr_out <= reg_wr_lat_r;
                    end else begin
                        reg_wr_out <= 1'b0;
                    end
                end
                default: begin
                    reg_wr_out <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else if (mis_err_s || timeout_s) begin
            mem_err <= 1'b1;
        end else if (err_clr) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= mem_err;
        end
    end

endmodule

// File: tb/tb_etapa_mem_wb.sv
// Scoreboard bench for etapa_mem_wb: the stimulus process models each
// instruction's architectural effect (including a small data memory) and
// queues the expected register write-backs; a monitor pops one entry for
// every cycle the stage presents a write-back.
module tb_etapa_mem_wb;

    localparam int MW = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_in;
    logic [31:0] B_in;
    logic [3:0]  dir_wb_in;
    logic        mem_wr_in;
    logic        sel_wb_in;
    logic        reg_wr_in;
    logic        sel_ld_in;
    logic        stall_out;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic        dm_req;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] result_out;
    logic [3:0]  dir_wb_out;
    logic        reg_wr_out;
    logic        mem_err;
    logic        err_clr;

    etapa_mem_wb #(.DATA_W(32), .REG_AW(4), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_in(alu_in), .B_in(B_in), .dir_wb_in(dir_wb_in),
        .mem_wr_in(mem_wr_in), .sel_wb_in(sel_wb_in), .reg_wr_in(reg_wr_in),
        .sel_ld_in(sel_ld_in), .stall_out(stall_out),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_req(dm_req),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .result_out(result_out), .dir_wb_out(dir_wb_out), .reg_wr_out(reg_wr_out),
        .mem_err(mem_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  dir;
    } wb_t;

    wb_t         exp_q[$];
    logic [31:0] mem_m[logic [31:0]];
    logic        err_m;
    int          total;
    int          bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with a register write is one retired instruction.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && reg_wr_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected got=%h/%0d want=none", result_out, dir_wb_out);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_result", result_out, e.res);
                chk("wb_dir", {28'd0, dir_wb_out}, {28'd0, e.dir});
            end
        end
    end

    task automatic garbage_inputs();
        alu_in    = $urandom;
        B_in      = $urandom;
        dir_wb_in = 4'($urandom);
        mem_wr_in = 1'($urandom);
        sel_ld_in = 1'($urandom);
        sel_wb_in = 1'($urandom);
        reg_wr_in = 1'($urandom);
        err_clr   = ($urandom_range(0, 3) == 0);
    endtask

    // One instruction; delay = WAIT cycle carrying the ack (1..MW+1), or -1 for none.
    task automatic instr(input logic [31:0] alu, input logic [31:0] b, input logic [3:0] dir,
                         input logic wr, input logic ld, input logic swb, input logic rw,
                         input logic clr, input int delay);
        logic        access;
        logic        mis;
        logic        acked;
        logic [31:0] rdata;
        logic        ended;
        wb_t         e;
        access = wr | ld;
        mis    = (alu[1:0] != 2'b00);
        acked  = (delay >= 1) && (delay <= MW + 1);
        rdata  = mem_m.exists(alu) ? mem_m[alu] : $urandom;
        alu_in = alu; B_in = b; dir_wb_in = dir; mem_wr_in = wr; sel_ld_in = ld;
        sel_wb_in = swb; reg_wr_in = rw; err_clr = clr; dm_ack = 1'b0;

        // Expected architectural outcome of this instruction.
        e.dir = dir;
        if (!access) begin
            e.res = alu;
            if (rw) exp_q.push_back(e);
        end else if (!mis && acked) begin
            e.res = (swb && !wr) ? rdata : alu;
            if (rw) exp_q.push_back(e);
            if (wr) mem_m[alu] = b;
        end

        #1;
        chk("stall_issue", {31'd0, stall_out}, {31'd0, access & ~mis});
        @(posedge clk);
        if (access && mis) err_m = 1'b1;
        else if (clr)      err_m = 1'b0;
        #1;
        chk("mem_err_issue", {31'd0, mem_err}, {31'd0, err_m});
        if (access) chk("bubble_rw", {31'd0, reg_wr_out}, 32'd0);
        if (!access || mis) begin
            chk("no_req", {31'd0, dm_req}, 32'd0);
        end else begin
            chk("req_start", {31'd0, dm_req}, 32'd1);
            chk("dm_addr", dm_addr, alu);
            chk("dm_we", {31'd0, dm_we}, {31'd0, wr});
            if (wr) chk("dm_wdata", dm_wdata, b);
            ended = 1'b0;
            for (int w = 1; w <= MW + 1 && !ended; w++) begin
                garbage_inputs();
                if (w == delay) begin
                    dm_ack   = 1'b1;
                    dm_rdata = rdata;
                end
                #1;
                ended = (w == delay) || (w == MW + 1);
                chk("stall_wait", {31'd0, stall_out}, {31'd0, ~ended});
                @(posedge clk);
                if (w != delay && w == MW + 1) err_m = 1'b1;
                else if (err_clr)              err_m = 1'b0;
                #1;
                dm_ack   = 1'b0;
                dm_rdata = $urandom;
                chk("mem_err_wait", {31'd0, mem_err}, {31'd0, err_m});
                if (ended) begin
                    chk("req_end", {31'd0, dm_req}, 32'd0);
                    if (w != delay) chk("abort_rw", {31'd0, reg_wr_out}, 32'd0);
                end else begin
                    chk("req_hold", {31'd0, dm_req}, 32'd1);
                    chk("addr_hold", dm_addr, alu);
                end
            end
        end
    endtask

    task automatic idle(input logic clr);
        instr($urandom, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, clr, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        int          d;
        total = 0; bad = 0; err_m = 1'b0;
        rst_n = 1'b0; dm_ack = 1'b0; dm_rdata = 32'd0; err_clr = 1'b0;
        alu_in = 32'd0; B_in = 32'd0; dir_wb_in = 4'd0;
        mem_wr_in = 1'b0; sel_ld_in = 1'b0; sel_wb_in = 1'b0; reg_wr_in = 1'b0;
        #12;
        chk("rst_result", result_out, 32'd0);
        chk("rst_ctrl", {26'd0, reg_wr_out, dm_req, dm_we, mem_err, stall_out, 1'b0}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        instr(32'h0000_1234, 32'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        mem_m[32'h100] = 32'hDEAD_BEEF;
        instr(32'h100, 32'd0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3);
        chk("load_result", result_out, 32'hDEAD_BEEF);
        instr(32'h20, 32'hCAFE_0001, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        instr(32'h0000_0042, 32'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        instr(32'h102, 32'd0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        chk("mis_err", {31'd0, mem_err}, 32'd1);
        idle(1'b1);
        chk("err_clr", {31'd0, mem_err}, 32'd0);
        instr(32'h40, 32'd0, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        chk("timeout_err", {31'd0, mem_err}, 32'd1);
        instr(32'h44, 32'h1111_2222, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, MW + 1);
        chk("both_store_res", result_out, 32'h44);
        idle(1'b1);

        // Reset while waiting: request drops at once, late ack ignored.
        alu_in = 32'h80; sel_ld_in = 1'b1; sel_wb_in = 1'b1; reg_wr_in = 1'b1;
        mem_wr_in = 1'b0; dir_wb_in = 4'd1; err_clr = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'd0, dm_req}, 32'd1);
        rst_n = 1'b0; err_m = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, dm_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_out}, 32'd0);
        chk("mid_rst_out", result_out | dm_addr | {28'd0, dir_wb_out}, 32'd0);
        chk("mid_rst_flags", {29'd0, reg_wr_out, mem_err, dm_we}, 32'd0);
        alu_in = 32'd0; sel_ld_in = 1'b0; reg_wr_in = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 32'hBAD0_BAD0;
        #1;
        chk("late_ack_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("late_ack_req", {31'd0, dm_req}, 32'd0);
        chk("late_ack_rw", {31'd0, reg_wr_out}, 32'd0);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            d = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, MW + 1);
            a = {26'd0, 4'($urandom), 2'b00};
            if (k <= 3) begin
                instr($urandom, $urandom, 4'($urandom), 1'b0, 1'b0, 1'($urandom),
                      1'($urandom_range(0, 3) != 0), $urandom_range(0, 7) == 0, 0);
            end else if (k <= 6) begin
                instr(a, $urandom, 4'($urandom), 1'b0, 1'b1, 1'($urandom_range(0, 3) != 0),
                      1'($urandom), $urandom_range(0, 7) == 0, d);
            end else if (k <= 8) begin
                instr(a, $urandom, 4'($urandom), 1'b1, 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(0, 7) == 0, d);
            end else begin
                instr(a | 32'($urandom_range(1, 3)), $urandom, 4'($urandom), 1'($urandom), 1'b1,
                      1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, d);
            end
        end
        idle(1'b0);
        idle(1'b0);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
